chdr_16sc_to_12sc: RTL and testbench

- Streaming CHDR packet converter between a CHDR source and a downstream CHDR sink on one 64-bit AXI-stream.
- Rewrites payload samples from 16-bit complex (sc16, 32 bits/sample) to packed 12-bit complex (sc12, 24 bits/sample).
- Fixes up the header length field.
- Optionally overrides the SID destination field from a settings-bus register.

---
 rtl/chdr_16sc_to_12sc_if.sv | 28 ++
 rtl/chdr_16sc_to_12sc.sv | 145 ++++++++++++++
 tb/tb_chdr_16sc_to_12sc.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/chdr_16sc_to_12sc_if.sv
// CHDR stream bundle between the sc16->sc12 converter and its environment.
// Signal names keep the converter's original port names.
interface chdr_16sc_to_12sc_if;
  logic [63:0] i_tdata;
  logic        i_tlast;
  logic        i_tvalid;
  logic        i_tready;
  logic [63:0] o_tdata;
  logic        o_tlast;
  logic        o_tvalid;
  logic        o_tready;

  // master: the environment (source upstream, sink downstream)
  modport master (
    output i_tdata, i_tlast, i_tvalid,
    input  i_tready,
    input  o_tdata, o_tlast, o_tvalid,
    output o_tready
  );

  // slave: the converter itself
  modport slave (
    input  i_tdata, i_tlast, i_tvalid,
    output i_tready,
    output o_tdata, o_tlast, o_tvalid,
    input  o_tready
  );
endinterface

// File: rtl/chdr_16sc_to_12sc.sv
// CHDR packet converter: sc16 payload -> packed sc12, header length fix-up,
// optional SID destination override from a settings-bus register.
module chdr_16sc_to_12sc #(
  parameter logic [7:0] BASE = 8'd0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      set_stb,
  input  logic [7:0]                set_addr,
  input  logic [31:0]               set_data,
  chdr_16sc_to_12sc_if.slave        axis,
  output logic [31:0]               debug
);

  typedef enum logic [1:0] {HEADER, TIME, PAYLOAD, FLUSH} state_t;

  state_t      r_state;
  logic        r_en;
  logic [15:0] r_dest;
  logic [15:0] r_remain;
  logic [63:0] r_acc;
  logic [6:0]  r_cnt;
  logic [63:0] r_odata;
  logic        r_olast;
  logic        r_ovalid;

  logic        w_ofree;
  logic        w_ready;
  logic        w_accept;
  logic        w_has_time;
  logic [15:0] w_hdr_bytes;
  logic [15:0] w_pay;
  logic [15:0] w_nsamp;
  logic [15:0] w_out_len;
  logic        w_bval;
  logic [47:0] w_new;
  logic [47:0] w_new_m;
  logic [6:0]  w_nbits;
  logic [6:0]  w_total;
  logic [111:0] w_cat;
  logic        w_unused_set;

  // upper settings bits are reserved
  assign w_unused_set = ^set_data[31:17];

  always_comb begin
    w_ofree     = !r_ovalid || axis.o_tready;
    w_ready     = w_ofree && (r_state != FLUSH);
    w_accept    = axis.i_tvalid && w_ready;
    w_has_time  = axis.i_tdata[61];
    w_hdr_bytes = w_has_time ? 16'd16 : 16'd8;
    w_pay       = axis.i_tdata[47:32] - w_hdr_bytes;
    w_nsamp     = w_pay >> 2;
    w_out_len   = w_hdr_bytes + (w_nsamp << 1) + w_nsamp;
    w_bval      = !axis.i_tlast || (r_remain >= 16'd8);
    w_new       = {axis.i_tdata[63:52], axis.i_tdata[47:36],
                   axis.i_tdata[31:20], axis.i_tdata[15:4]};
    w_new_m     = w_bval ? w_new : {w_new[47:24], 24'b0};
    w_nbits     = w_bval ? 7'd48 : 7'd24;
    w_total     = r_cnt + w_nbits;
    // residual sits left-aligned in r_acc; new bits land directly after it
    w_cat       = {r_acc, 48'b0} | ({w_new_m, 64'b0} >> r_cnt);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= HEADER;
      r_en     <= 1'b0;
      r_dest   <= '0;
      r_remain <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_odata  <= '0;
      r_olast  <= 1'b0;
      r_ovalid <= 1'b0;
    end else begin
      if (set_stb && (set_addr == BASE)) begin
        r_en   <= set_data[16];
        r_dest <= set_data[15:0];
      end
      if (w_ofree) r_ovalid <= 1'b0;
      case (r_state)
        HEADER: if (w_accept) begin
          r_ovalid <= 1'b1;
          r_olast  <= axis.i_tlast;
          r_odata  <= {axis.i_tdata[63:48], w_out_len, axis.i_tdata[31:16],
                       r_en ? r_dest : axis.i_tdata[15:0]};
          r_remain <= w_pay;
          r_acc    <= '0;
          r_cnt    <= '0;
          if (!axis.i_tlast) r_state <= w_has_time ? TIME : PAYLOAD;
        end
        TIME: if (w_accept) begin
          r_ovalid <= 1'b1;
          r_olast  <= axis.i_tlast;
          r_odata  <= axis.i_tdata;
          r_state  <= axis.i_tlast ? HEADER : PAYLOAD;
        end
        PAYLOAD: if (w_accept) begin
          r_remain <= (r_remain >= 16'd8) ? r_remain - 16'd8 : '0;
          if (axis.i_tlast) begin
            r_ovalid <= 1'b1;
            r_odata  <= w_cat[111:48];
            if (w_total > 7'd64) begin
              r_olast <= 1'b0;
              r_acc   <= {w_cat[47:0], 16'b0};
              r_cnt   <= w_total - 7'd64;
              r_state <= FLUSH;
            end else begin
              r_olast <= 1'b1;
              r_acc   <= '0;
              r_cnt   <= '0;
              r_state <= HEADER;
            end
          end else if (w_total >= 7'd64) begin
            r_ovalid <= 1'b1;
            r_olast  <= 1'b0;
            r_odata  <= w_cat[111:48];
            r_acc    <= {w_cat[47:0], 16'b0};
            r_cnt    <= w_total - 7'd64;
          end else begin
            r_acc <= w_cat[111:48];
            r_cnt <= w_total;
          end
        end
        FLUSH: if (w_ofree) begin
          r_ovalid <= 1'b1;
          r_olast  <= 1'b1;
          r_odata  <= r_acc;
          r_acc    <= '0;
          r_cnt    <= '0;
          r_state  <= HEADER;
        end
        default: r_state <= HEADER;
      endcase
    end
  end

  assign axis.i_tready = w_ready;
  assign axis.o_tdata  = r_odata;
  assign axis.o_tlast  = r_olast;
  assign axis.o_tvalid = r_ovalid;
  assign debug         = {2'b00, r_state, 1'b0, r_cnt, 20'b0};

endmodule

// File: tb/tb_chdr_16sc_to_12sc.sv
// Bench for chdr_16sc_to_12sc: fixed vectors, reset corner cases and random
// packets compared against a bit-queue reference model.
module tb_chdr_16sc_to_12sc;
  localparam logic [7:0] BASE = 8'h40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        set_stb = 1'b0;
  logic [7:0]  set_addr = '0;
  logic [31:0] set_data = '0;
  logic [31:0] debug;

  chdr_16sc_to_12sc_if bus();

  chdr_16sc_to_12sc #(.BASE(BASE)) dut (
    .clk(clk), .reset(rst_n), .set_stb(set_stb), .set_addr(set_addr),
    .set_data(set_data), .axis(bus), .debug(debug)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned plen;
    bit          en;
    bit          rnd;
    logic [15:0] exp_len;
    logic [31:0] exp_sid;
    int unsigned exp_n;
    logic [63:0] exp_last;
    bit          exp_flush;
  } vec_t;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  logic [64:0] in_q[$];
  logic [64:0] exp_q[$];
  logic [64:0] got_q[$];
  bit          m_en = 1'b0;
  logic [15:0] m_dest = '0;
  bit          rdy_rand = 1'b0;

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic write_set(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    set_stb = 1'b1; set_addr = a; set_data = d;
    @(negedge clk);
    set_stb = 1'b0;
    if (a == BASE) begin m_en = d[16]; m_dest = d[15:0]; end
  endtask

  // Reference: take the first N sc16 samples, truncate each to 24 bits,
  // concatenate MSB-first and cut into 64-bit lines.
  task automatic make_pkt(input bit ht, input int unsigned plen, input logic [31:0] sid,
                          input logic [11:0] seq, input logic [63:0] tstamp,
                          input logic [2:0] fl, input bit fixed);
    int unsigned hb;
    int unsigned ns;
    int unsigned nl;
    logic [31:0] smp[$];
    bit          bq[$];
    logic [63:0] w;
    logic [15:0] flags;
    logic [23:0] c;
    hb = ht ? 16 : 8;
    ns = plen / 4;
    nl = (plen + 7) / 8;
    in_q.delete(); exp_q.delete();
    flags = {fl[2:1], ht, fl[0], seq};
    in_q.push_back({1'b0, flags, 16'(plen + hb), sid});
    exp_q.push_back({1'b0, flags, 16'(hb + 3 * ns), sid[31:16], m_en ? m_dest : sid[15:0]});
    if (ht) begin
      in_q.push_back({1'b0, tstamp});
      exp_q.push_back({1'b0, tstamp});
    end
    for (int unsigned k = 0; k < nl; k++) begin
      w = fixed ? 64'h1234_5678_9ABC_DEF0 : {$urandom, $urandom};
      in_q.push_back({(k == nl - 1), w});
      smp.push_back(w[63:32]);
      smp.push_back(w[31:0]);
    end
    for (int unsigned s = 0; s < ns; s++) begin
      c = {smp[s][31:20], smp[s][15:4]};
      for (int b = 23; b >= 0; b--) bq.push_back(c[b]);
    end
    while (bq.size() > 0) begin
      w = '0;
      for (int b = 63; b >= 0; b--) if (bq.size() > 0) w[b] = bq.pop_front();
      exp_q.push_back({(bq.size() == 0), w});
    end
  endtask

  task automatic run_pkt(input bit gaps, input int unsigned nmax, output bit rdy_after);
    int unsigned i;
    int unsigned cyc;
    i = 0; cyc = 0;
    got_q.delete();
    while (i < nmax && i < in_q.size()) begin
      @(negedge clk);
      if (gaps && $urandom_range(0, 3) == 0) bus.i_tvalid = 1'b0;
      else begin
        bus.i_tvalid = 1'b1;
        bus.i_tdata  = in_q[i][63:0];
        bus.i_tlast  = in_q[i][64];
      end
      #1;
      if (bus.i_tvalid && bus.i_tready) i++;
      cyc++;
      if (cyc > 5000) begin
        n_checks++; n_fail++;
        $display("FAIL in_timeout accepted=%0d required=%0d", i, in_q.size());
        break;
      end
    end
    @(negedge clk);
    bus.i_tvalid = 1'b0; bus.i_tlast = 1'b0;
    #1;
    rdy_after = bus.i_tready;
  endtask

  task automatic compare_pkt(input string tag);
    int unsigned cyc;
    cyc = 0;
    while (got_q.size() < exp_q.size() && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    repeat (6) @(negedge clk);
    check({tag, "_nlines"}, 65'(got_q.size()), 65'(exp_q.size()));
    foreach (exp_q[k])
      if (k < got_q.size()) check($sformatf("%s_line%0d", tag, k), got_q[k], exp_q[k]);
  endtask

  // Output sink: random backpressure, capture, and hold-stability check.
  logic [64:0] held = '0;
  bit          stalled = 1'b0;
  initial begin
    bus.o_tready = 1'b1;
    forever begin
      @(negedge clk);
      bus.o_tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (!rst_n) stalled = 1'b0;
      else begin
        if (stalled) check("hold", {bus.o_tlast, bus.o_tdata}, held);
        if (bus.o_tvalid && bus.o_tready) got_q.push_back({bus.o_tlast, bus.o_tdata});
        stalled = bus.o_tvalid && !bus.o_tready;
        held = {bus.o_tlast, bus.o_tdata};
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tv[6];
    bit          ra;
    logic [64:0] hdr;
    logic [64:0] lst;

    bus.i_tvalid = 1'b0; bus.i_tlast = 1'b0; bus.i_tdata = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_o_tvalid", 65'(bus.o_tvalid), 65'(0));
    check("rst_o_tlast", 65'(bus.o_tlast), 65'(0));
    check("rst_o_tdata", 65'(bus.o_tdata), 65'(0));
    check("rst_i_tready", 65'(bus.i_tready), 65'(1));
    check("rst_debug", 65'(debug[27:0]), 65'(0));
    @(negedge clk);
    rst_n = 1'b1;

    tv[0] = '{4,  1'b1, 1'b0, 16'd19, 32'hDEAD_FEED, 3, 64'h1235_6700_0000_0000, 1'b0};
    tv[1] = '{8,  1'b1, 1'b0, 16'd22, 32'hDEAD_FEED, 3, 64'h1235_679A_BDEF_0000, 1'b0};
    tv[2] = '{12, 1'b1, 1'b0, 16'd25, 32'hDEAD_FEED, 4, 64'h6700_0000_0000_0000, 1'b1};
    tv[3] = '{32, 1'b1, 1'b0, 16'd40, 32'hDEAD_FEED, 5, 64'hBDEF_1235_679A_BDEF, 1'b0};
    tv[4] = '{28, 1'b1, 1'b0, 16'd37, 32'hDEAD_FEED, 5, 64'hBDEF_1235_6700_0000, 1'b0};
    tv[5] = '{12, 1'b0, 1'b1, 16'd25, 32'hDEAD_BEEF, 4, 64'h6700_0000_0000_0000, 1'b1};

    foreach (tv[v]) begin
      write_set(BASE, {15'b0, tv[v].en, 16'hFEED});
      write_set(BASE + 8'd1, 32'h0);  // foreign address must leave the register alone
      rdy_rand = tv[v].rnd;
      make_pkt(1'b1, tv[v].plen, 32'hDEAD_BEEF, 12'h0, 64'h0, 3'b000, 1'b1);
      run_pkt(tv[v].rnd, 1000, ra);
      compare_pkt($sformatf("vec%0d", v));
      hdr = (got_q.size() > 0) ? got_q[0] : '0;
      lst = (got_q.size() > 0) ? got_q[got_q.size() - 1] : '0;
      check($sformatf("vec%0d_len", v), 65'(hdr[47:32]), 65'(tv[v].exp_len));
      check($sformatf("vec%0d_sid", v), 65'(hdr[31:0]), 65'(tv[v].exp_sid));
      check($sformatf("vec%0d_count", v), 65'(got_q.size()), 65'(tv[v].exp_n));
      check($sformatf("vec%0d_lastline", v), lst, {1'b1, tv[v].exp_last});
      if (!tv[v].rnd) check($sformatf("vec%0d_ready_after", v), 65'(ra), 65'(!tv[v].exp_flush));
    end
    rdy_rand = 1'b0;

    // reset in the middle of a packet, then a clean packet with defaults
    make_pkt(1'b1, 40, 32'h0102_0304, 12'h5, 64'h77, 3'b000, 1'b0);
    run_pkt(1'b0, 3, ra);
    check("midpkt_residual", 65'(debug[27:20]), 65'(48));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_o_tvalid", 65'(bus.o_tvalid), 65'(0));
    check("midrst_debug", 65'(debug[27:0]), 65'(0));
    @(negedge clk);
    rst_n = 1'b1;
    m_en = 1'b0; m_dest = '0;
    make_pkt(1'b0, 20, 32'hCAFE_0123, 12'h9, 64'h0, 3'b101, 1'b0);
    run_pkt(1'b0, 1000, ra);
    compare_pkt("post_rst");

    for (int unsigned p = 0; p < 40; p++) begin
      if ($urandom_range(0, 2) == 0) write_set(BASE, $urandom);
      rdy_rand = 1'b1;
      make_pkt(1'($urandom_range(0, 1)), 4 * $urandom_range(1, 48), $urandom,
               12'($urandom), {$urandom, $urandom}, 3'($urandom), 1'b0);
      run_pkt(1'b1, 1000, ra);
      compare_pkt($sformatf("rnd%0d", p));
    end
    rdy_rand = 1'b0;

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
